bu_pipe: RTL and testbench
==========================

BU_PIPE -- requirements
Module: bu_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/PC width (>=8).
REQ-002 Parameter STAGES, default 2, pipeline depth, legal values 1 or 2.
REQ-003 Parameter CNT_W, default 16, mispredict counter width.
REQ-004 i_clk  in  1  single clock; all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_valid  in  1  upstream branch request valid.
REQ-007 o_ready  out  1  block can accept a request this cycle.
REQ-008 i_a, i_b  in  XLEN  rs1/rs2 operands.
REQ-009 i_cmp_op  in  3  compare opcode (RISC-V funct3).
REQ-010 i_pc, i_imm  in  XLEN  branch PC and sign-extended offset.
REQ-011 i_pred_taken  in  1  front-end prediction.
REQ-012 i_flush  in  1  kill all in-flight requests.
REQ-013 o_valid  out  1  result valid.
REQ-014 i_ready  in  1  downstream accepts result.
REQ-015 o_taken, o_mispredict, o_misalign, o_illegal  out  1 each  resolution flags.
REQ-016 o_redirect_pc  out  XLEN  correct next PC.
REQ-017 o_mispred_cnt  out  CNT_W  saturating count of retired mispredicts.

Function
REQ-018 Opcodes SHALL be BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111; 010/011 illegal.
REQ-019 BLT/BGE SHALL compare two's-complement signed, BLTU/BGEU unsigned, all XLEN bits.
REQ-020 Illegal opcode: o_taken=0, o_illegal=1, o_mispredict=0, o_redirect_pc=i_pc+4, no counter update.
REQ-021 Target = i_pc + i_imm, fallthrough = i_pc + 4, both modulo 2^XLEN (wrap, no carry out).
REQ-022 o_redirect_pc SHALL be target if taken else fallthrough.
REQ-023 o_mispredict = legal && (o_taken != i_pred_taken).
REQ-024 o_misalign = taken && target[1:0] != 0; redirect_pc still reports target.
REQ-025 Request accepted when i_valid && o_ready; result appears on o_valid exactly STAGES cycles later absent stalls.
REQ-026 STAGES=2: stage 1 registers compare result and target/fallthrough; stage 2 registers redirect/mispredict/misalign.
REQ-027 Each stage holds its data while occupied and not advancing; stage advances when downstream empty or consuming.
REQ-028 o_ready = !last_valid || i_ready propagated back through each stage (full throughput 1/cycle, no bubbles under continuous i_ready).
REQ-029 Output fields SHALL stay stable while o_valid && !i_ready.
REQ-030 i_flush SHALL clear every stage valid bit at the next edge; a request offered in the flush cycle is discarded; o_ready=1 during flush.
REQ-031 Flush has priority over acceptance and over counter increment for results not yet handshaken; a result handshaken in the flush cycle counts.
REQ-032 o_mispred_cnt increments by 1 on each o_valid && i_ready with o_mispredict=1; saturates at 2^CNT_W-1.
REQ-033 Invalid STAGES SHALL be rejected at elaboration.

Reset
REQ-034 On i_rst_n=0, asynchronously: all stage valids 0, o_valid=0, o_mispred_cnt=0; data registers need not reset.
REQ-035 Reset mid-operation discards all in-flight requests; o_ready=1 the first cycle after release.
REQ-036 Outputs other than o_valid/o_ready/o_mispred_cnt SHALL be don't-care while o_valid=0.

Structure
REQ-037 Opcode encodings (REQ-018) SHALL live in the shared branch-unit constants header, reused by decoder and bench.
REQ-038 One sub-module, bu_cmp: combinational, parametrised XLEN, (a, b, op) -> (taken, illegal).
REQ-039 Pipeline stages SHALL be generated from STAGES, not duplicated by hand.

Verification
REQ-040 BLT a=0xFFFFFFFF, b=1, pred=0 -> taken=1, mispredict=1, redirect=pc+imm; BLTU same operands -> taken=0.
REQ-041 pc=0xFFFFFFFC, imm=8, BEQ a=b -> redirect=0x00000004 (wrap); not-taken -> redirect=0x00000000.
REQ-042 10 back-to-back requests, i_ready=1 -> 10 results in order, STAGES cycles latency, no bubbles; then i_ready=0 for 3 cycles -> outputs held, o_ready drops once pipe full.
REQ-043 i_flush with 2 in flight -> o_valid=0 next cycle, counter unchanged; opcode 010 -> o_illegal=1, redirect=pc+4.
REQ-044 CNT_W=2, 5 mispredicts retired -> o_mispred_cnt=3; async reset mid-stream -> o_valid=0, count=0 immediately.
REQ-045 Taken BNE, imm=6 -> o_misalign=1; repeat all scenarios for STAGES=1 and XLEN=64.

Source files
------------

// File: rtl/bu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// bu_pipe_pkg -- shared branch-unit constants.
//
// Holds the conditional-branch compare opcodes (RISC-V funct3 encodings), the
// fall-through PC step and a legality helper. The package is imported by the
// compare decoder, the pipeline top and the testbench, so the encodings exist
// in exactly one place.
// ---------------------------------------------------------------------------
package bu_pipe_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_op_e;

  // Distance from a branch to the instruction that follows it.
  localparam int unsigned PC_STEP = 4;

  // Only the two reserved encodings 010/011 are illegal.
  function automatic logic br_op_legal(input logic [2:0] op);
    return op[2] || !op[1];
  endfunction

endpackage

// File: rtl/bu_pipe_cmp.sv
// ---------------------------------------------------------------------------
// bu_cmp -- combinational branch condition evaluator.
//
// Parameters:
//   XLEN       operand width
// Ports:
//   a_i        rs1 operand
//   b_i        rs2 operand
//   op_i       compare opcode (funct3)
//   taken_o    condition holds (forced 0 for illegal opcodes)
//   illegal_o  opcode is one of the reserved encodings
// ---------------------------------------------------------------------------
module bu_cmp
  import bu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      op_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  assign a_s  = a_i;
  assign b_s  = b_i;
  assign eq   = (a_i == b_i);
  assign lt_s = (a_s < b_s);
  assign lt_u = (a_i < b_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = !br_op_legal(op_i);
    case (br_op_e'(op_i))
      BR_BEQ:  taken_o = eq;
      BR_BNE:  taken_o = !eq;
      BR_BLT:  taken_o = lt_s;
      BR_BGE:  taken_o = !lt_s;
      BR_BLTU: taken_o = lt_u;
      BR_BGEU: taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bu_pipe.sv
// ---------------------------------------------------------------------------
// bu_pipe -- pipelined conditional-branch resolution unit.
//
// Evaluates a branch condition, computes target (pc+imm) and fall-through
// (pc+4), and reports the corrected next PC together with taken, mispredict,
// misalign and illegal flags. Requests flow through STAGES register stages
// with valid/ready handshaking; a saturating counter tracks retired
// mispredicts.
//
// Parameters:
//   XLEN    operand / PC width (>= 8)
//   STAGES  pipeline depth, 1 or 2
//   CNT_W   mispredict counter width
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       request handshake
//   i_a, i_b, i_cmp_op      operands and funct3 compare opcode
//   i_pc, i_imm             branch PC and sign-extended offset
//   i_pred_taken            front-end prediction
//   i_flush                 kill all in-flight requests
//   o_valid / i_ready       result handshake
//   o_taken, o_mispredict, o_misalign, o_illegal   resolution flags
//   o_redirect_pc           correct next PC
//   o_mispred_cnt           saturating count of retired mispredicts
// ---------------------------------------------------------------------------
module bu_pipe
  import bu_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [2:0]       i_cmp_op,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_pred_taken,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic             o_mispredict,
  output logic             o_misalign,
  output logic             o_illegal,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  if ((STAGES != 1) && (STAGES != 2)) begin : g_bad_stages
    $error("bu_pipe: STAGES must be 1 or 2");
  end
  if (XLEN < 8) begin : g_bad_xlen
    $error("bu_pipe: XLEN must be at least 8");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("bu_pipe: CNT_W must be at least 1");
  end

  // One payload format is carried by every stage. Early stages only fill the
  // compare result and the two candidate PCs; the stage that feeds the output
  // resolves redirect/mispredict/misalign just before it registers them.
  typedef struct packed {
    logic            taken;
    logic            illegal;
    logic            pred;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthru;
    logic [XLEN-1:0] redirect;
    logic            mispred;
    logic            misalign;
  } stage_t;

  function automatic stage_t resolve(input stage_t s);
    stage_t r;
    r          = s;
    r.redirect = s.taken ? s.target : s.fallthru;
    r.mispred  = !s.illegal && (s.taken != s.pred);
    // A taken branch to a non-word-aligned target still reports that target.
    r.misalign = s.taken && (s.target[1:0] != 2'b00);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic            cmp_taken;
  logic            cmp_illegal;
  stage_t          entry;

  stage_t          stg_q [STAGES];
  stage_t          stg_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] in_vld;
  logic [STAGES-1:0] stg_rdy;
  logic [STAGES-1:0] nxt_rdy;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             retire;

  bu_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .a_i       (i_a),
    .b_i       (i_b),
    .op_i      (i_cmp_op),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  // Entry: compare result and both candidate PCs, modulo 2^XLEN.
  always_comb begin
    entry          = '0;
    entry.taken    = cmp_taken;
    entry.illegal  = cmp_illegal;
    entry.pred     = i_pred_taken;
    entry.target   = i_pc + i_imm;
    entry.fallthru = i_pc + XLEN'(PC_STEP);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t src;

    if (k == 0) begin : g_head
      assign src       = entry;
      assign in_vld[k] = i_valid;
    end else begin : g_body
      assign src       = stg_q[k-1];
      assign in_vld[k] = vld_q[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign stg_d[k]   = resolve(src);
      assign nxt_rdy[k] = i_ready;
    end else begin : g_mid
      assign stg_d[k]   = src;
      assign nxt_rdy[k] = stg_rdy[k+1];
    end

    // A stage may take new data when it is empty or its contents move on.
    assign stg_rdy[k] = !vld_q[k] || nxt_rdy[k];

    // Stage k boundary: occupancy (flush beats acceptance).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        vld_q[k] <= 1'b0;
      end else if (i_flush) begin
        vld_q[k] <= 1'b0;
      end else if (stg_rdy[k]) begin
        vld_q[k] <= in_vld[k];
      end
    end

    // Stage k boundary: payload, held while stalled, never reset.
    always_ff @(posedge i_clk) begin
      if (stg_rdy[k] && in_vld[k]) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  // Flush empties every stage at the next edge, so the block can always
  // accept during a flush cycle (the offered request is dropped anyway).
  assign o_ready = stg_rdy[0] || i_flush;

  assign o_valid       = vld_q[STAGES-1];
  assign o_taken       = stg_q[STAGES-1].taken;
  assign o_illegal     = stg_q[STAGES-1].illegal;
  assign o_mispredict  = stg_q[STAGES-1].mispred;
  assign o_misalign    = stg_q[STAGES-1].misalign;
  assign o_redirect_pc = stg_q[STAGES-1].redirect;

  // A result handshaken in a flush cycle has retired and still counts.
  assign retire = o_valid && i_ready && o_mispredict;

  always_comb begin
    cnt_d = cnt_q;
    if (retire) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_mispred_cnt = cnt_q;

endmodule

// File: tb/tb_bu_pipe.sv
// ---------------------------------------------------------------------------
// tb_bu_pipe -- scoreboard bench for bu_pipe.
//
// Three instances (XLEN=32/STAGES=2, XLEN=32/STAGES=1, XLEN=64/STAGES=2,
// all CNT_W=2) are exercised one at a time with the same directed vectors.
// 64-bit operands are sign extensions of the 32-bit vectors, chosen so the
// 64-bit results are the sign extensions of the 32-bit results.
// ---------------------------------------------------------------------------
module tb_bu_pipe;
  import bu_pipe_pkg::*;

  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  logic        tb_valid = 1'b0;
  logic        tb_ready = 1'b1;
  logic        tb_flush = 1'b0;
  logic        tb_pred  = 1'b0;
  logic [2:0]  tb_op    = 3'b000;
  logic [31:0] a32 = '0, b32 = '0, pc32 = '0, imm32 = '0;
  logic [63:0] a64, b64, pc64, imm64;

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  assign a64   = sx(a32);
  assign b64   = sx(b32);
  assign pc64  = sx(pc32);
  assign imm64 = sx(imm32);

  logic v0, v1, v2;
  assign v0 = tb_valid && (sel == 0);
  assign v1 = tb_valid && (sel == 1);
  assign v2 = tb_valid && (sel == 2);

  logic          r0, vl0, tk0, mp0, ma0, il0;
  logic [31:0]   red0;
  logic [CW-1:0] cn0;
  logic          r1, vl1, tk1, mp1, ma1, il1;
  logic [31:0]   red1;
  logic [CW-1:0] cn1;
  logic          r2, vl2, tk2, mp2, ma2, il2;
  logic [63:0]   red2;
  logic [CW-1:0] cn2;

  bu_pipe #(.XLEN(32), .STAGES(2), .CNT_W(CW)) u_s2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(r0),
    .i_a(a32), .i_b(b32), .i_cmp_op(tb_op), .i_pc(pc32), .i_imm(imm32),
    .i_pred_taken(tb_pred), .i_flush(tb_flush), .o_valid(vl0), .i_ready(tb_ready),
    .o_taken(tk0), .o_mispredict(mp0), .o_misalign(ma0), .o_illegal(il0),
    .o_redirect_pc(red0), .o_mispred_cnt(cn0));

  bu_pipe #(.XLEN(32), .STAGES(1), .CNT_W(CW)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(r1),
    .i_a(a32), .i_b(b32), .i_cmp_op(tb_op), .i_pc(pc32), .i_imm(imm32),
    .i_pred_taken(tb_pred), .i_flush(tb_flush), .o_valid(vl1), .i_ready(tb_ready),
    .o_taken(tk1), .o_mispredict(mp1), .o_misalign(ma1), .o_illegal(il1),
    .o_redirect_pc(red1), .o_mispred_cnt(cn1));

  bu_pipe #(.XLEN(64), .STAGES(2), .CNT_W(CW)) u_w64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(r2),
    .i_a(a64), .i_b(b64), .i_cmp_op(tb_op), .i_pc(pc64), .i_imm(imm64),
    .i_pred_taken(tb_pred), .i_flush(tb_flush), .o_valid(vl2), .i_ready(tb_ready),
    .o_taken(tk2), .o_mispredict(mp2), .o_misalign(ma2), .o_illegal(il2),
    .o_redirect_pc(red2), .o_mispred_cnt(cn2));

  // View of whichever instance is selected.
  logic          m_ready, m_valid;
  logic [3:0]    m_flg;
  logic [63:0]   m_red;
  logic [CW-1:0] m_cnt;

  always_comb begin
    m_ready = r0;  m_valid = vl0; m_flg = {tk0, mp0, ma0, il0};
    m_red   = sx(red0); m_cnt = cn0;
    if (sel == 1) begin
      m_ready = r1;  m_valid = vl1; m_flg = {tk1, mp1, ma1, il1};
      m_red   = sx(red1); m_cnt = cn1;
    end else if (sel == 2) begin
      m_ready = r2;  m_valid = vl2; m_flg = {tk2, mp2, ma2, il2};
      m_red   = red2; m_cnt = cn2;
    end
  end

  // flg = {taken, mispredict, misalign, illegal}
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pc, imm;
    logic        pred;
    logic [3:0]  flg;
    logic [31:0] red;
  } vec_t;

  typedef struct {
    logic [3:0]  flg;
    logic [63:0] red;
    bit          chk;
    int          cyc;
  } exp_t;

  vec_t vt [13];
  exp_t sbq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cfg=%0d t=%0t got=%h want=%h", name, sel, $time, act, req);
    end
  endtask

  function automatic int stg();
    return (sel == 1) ? 1 : 2;
  endfunction

  task automatic set_vec(input int i);
    tb_op = vt[i].op; a32 = vt[i].a; b32 = vt[i].b;
    pc32 = vt[i].pc; imm32 = vt[i].imm; tb_pred = vt[i].pred;
  endtask

  task automatic push_exp(input int i, input bit lat, input int c);
    exp_t e;
    e.flg = vt[i].flg; e.red = sx(vt[i].red); e.chk = lat; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    if (rst_n && m_valid && tb_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 64'(m_flg), 64'hDEAD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("flags", 64'(m_flg), 64'(e.flg));
        chk("redirect", m_red, e.red);
        if (e.chk) chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input int i, input bit lat);
    int t;
    t = 0;
    set_vec(i);
    tb_valid = 1'b1;
    while (!m_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!m_ready) begin
      chk("send_timeout", 64'(t), 64'(0));
    end else begin
      push_exp(i, lat, cyc + stg());
      @(posedge clk); #1;
    end
    tb_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(posedge clk); t++;
    end
    chk("drain_left", 64'(sbq.size()), 64'(0));
    #1;
  endtask

  task automatic fill_stalled();
    tb_ready = 1'b0;
    for (int i = 0; i < stg(); i++) begin
      set_vec((i == 0) ? 0 : 6);
      tb_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("fill_ready", 64'(m_ready), 64'(0));
  endtask

  task automatic run_cfg(input int s);
    int n;
    sel = s; tb_valid = 1'b0; tb_ready = 1'b1; tb_flush = 1'b0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    chk("rst_ready", 64'(m_ready), 64'(1));
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_cnt", 64'(m_cnt), 64'(0));

    // Flush with a full stalled pipe; the request offered alongside is dropped
    fill_stalled();
    set_vec(7); tb_valid = 1'b1; tb_flush = 1'b1;
    #1;
    chk("flush_ready", 64'(m_ready), 64'(1));
    @(posedge clk); #1;
    tb_flush = 1'b0; tb_valid = 1'b0; tb_ready = 1'b1;
    chk("flush_valid", 64'(m_valid), 64'(0));
    repeat (3) @(posedge clk); #1;
    chk("flush_valid_later", 64'(m_valid), 64'(0));
    chk("flush_cnt", 64'(m_cnt), 64'(0));

    // Head handshaken in the flush cycle retires and counts
    fill_stalled();
    tb_valid = 1'b0;
    push_exp(0, 1'b0, 0);
    tb_flush = 1'b1; tb_ready = 1'b1;
    @(posedge clk); #1;
    tb_flush = 1'b0;
    chk("flush_hs_valid", 64'(m_valid), 64'(0));
    repeat (2) @(posedge clk); #1;
    chk("flush_hs_cnt", 64'(m_cnt), 64'(1));
    chk("flush_hs_sb", 64'(sbq.size()), 64'(0));

    // Back-to-back, full throughput, exact latency (six more mispredicts)
    for (int i = 0; i < 13; i++) send(i, 1'b1);
    drain();
    repeat (2) @(posedge clk); #1;
    chk("sat_cnt", 64'(m_cnt), 64'(3));

    // Downstream stall: head held, o_ready drops once the pipe is full
    tb_ready = 1'b0;
    n = 0;
    for (int c = 0; c < stg() + 3; c++) begin
      set_vec((n < stg()) ? n + 1 : 9);
      tb_valid = 1'b1;
      @(negedge clk);
      chk("stall_ready", 64'(m_ready), 64'(n < stg()));
      chk("stall_valid", 64'(m_valid), 64'(c >= stg()));
      if (c >= stg()) begin
        chk("stall_hold_red", m_red, sx(vt[1].red));
        chk("stall_hold_flg", 64'(m_flg), 64'(vt[1].flg));
      end
      if (n < stg()) begin
        push_exp(n + 1, 1'b0, 0);
        n++;
      end
      @(posedge clk); #1;
    end
    tb_valid = 1'b0; tb_ready = 1'b1;
    drain();

    // Asynchronous reset mid-stream
    tb_ready = 1'b0;
    set_vec(0); tb_valid = 1'b1;
    repeat (stg()) @(posedge clk);
    #1;
    chk("arst_pre_valid", 64'(m_valid), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(m_valid), 64'(0));
    chk("arst_cnt", 64'(m_cnt), 64'(0));
    tb_valid = 1'b0;
    sbq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready", 64'(m_ready), 64'(1));
    chk("arst_valid_after", 64'(m_valid), 64'(0));
    tb_ready = 1'b1;
  endtask

  initial begin
    //           op       a             b             pc            imm           pred  flg      red
    vt[0]  = '{BR_BLT,  32'hFFFFFFFF, 32'h00000001, 32'h00001000, 32'h00000020, 1'b0, 4'b1100, 32'h00001020};
    vt[1]  = '{BR_BLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00001000, 32'h00000020, 1'b0, 4'b0000, 32'h00001004};
    vt[2]  = '{BR_BEQ,  32'h00000005, 32'h00000005, 32'hFFFFFFFC, 32'h00000008, 1'b1, 4'b1000, 32'h00000004};
    vt[3]  = '{BR_BEQ,  32'h00000005, 32'h00000006, 32'hFFFFFFFC, 32'h00000008, 1'b0, 4'b0000, 32'h00000000};
    vt[4]  = '{BR_RSV2, 32'h00000001, 32'h00000001, 32'h00002000, 32'h00000040, 1'b1, 4'b0001, 32'h00002004};
    vt[5]  = '{BR_BNE,  32'h00000001, 32'h00000002, 32'h00003000, 32'h00000006, 1'b1, 4'b1010, 32'h00003006};
    vt[6]  = '{BR_BGE,  32'h80000000, 32'h7FFFFFFF, 32'h00004000, 32'h00000100, 1'b1, 4'b0100, 32'h00004004};
    vt[7]  = '{BR_BGEU, 32'h80000000, 32'h7FFFFFFF, 32'h00004000, 32'h00000100, 1'b0, 4'b1100, 32'h00004100};
    vt[8]  = '{BR_BNE,  32'h00000007, 32'h00000007, 32'h00005000, 32'hFFFFFFF0, 1'b0, 4'b0000, 32'h00005004};
    vt[9]  = '{BR_BEQ,  32'h00000009, 32'h00000009, 32'h00005000, 32'hFFFFFFF0, 1'b0, 4'b1100, 32'h00004FF0};
    vt[10] = '{BR_BLT,  32'h00000003, 32'h00000003, 32'h00006000, 32'h00000010, 1'b1, 4'b0100, 32'h00006004};
    vt[11] = '{BR_BGE,  32'h00000003, 32'h00000003, 32'h00006000, 32'h00000010, 1'b0, 4'b1100, 32'h00006010};
    vt[12] = '{BR_RSV3, 32'h00000000, 32'h00000000, 32'h00007000, 32'h00000008, 1'b0, 4'b0001, 32'h00007004};

    for (int s = 0; s < 3; s++) run_cfg(s);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
